// File: rtl/mp_counter.sv
// Two-digit BCD up/down counter (00-99) with a multiplexed, active-low
// seven-segment display driver. Only the two low digits of the display are used.
module mp_counter #(
    parameter int TICK_DIV = 1,
    parameter int SCAN_DIV = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       STYLE,
    output logic [6:0] DISP,
    output logic [3:0] AN,
    output logic [3:0] ONES,
    output logic [3:0] TENS
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] scanCnt_q, scanCnt_d;
    logic          scanIdx_q, scanIdx_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic          tick;
    logic [3:0]    shownDigit;

    function automatic logic [6:0] segDecode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // The prescaler only advances while enabled, so a paused count resumes
    // with the same phase instead of restarting its divide period.
    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (EN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (tick) begin
            if (STYLE) begin
                if (ones_q == 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end else begin
                if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end
    end

    // Display scan is free-running and ignores EN.
    always_comb begin
        scanCnt_d = scanCnt_q;
        scanIdx_d = scanIdx_q;
        if (scanCnt_q == SCAN_LAST) begin
            scanCnt_d = '0;
            scanIdx_d = ~scanIdx_q;
        end else begin
            scanCnt_d = scanCnt_q + SW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            presc_q   <= '0;
            scanCnt_q <= '0;
            scanIdx_q <= 1'b0;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
        end else begin
            presc_q   <= presc_d;
            scanCnt_q <= scanCnt_d;
            scanIdx_q <= scanIdx_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
        end
    end

    always_comb begin
        shownDigit = scanIdx_q ? tens_q : ones_q;
        AN         = scanIdx_q ? 4'b1101 : 4'b1110;
        DISP       = segDecode(shownDigit);
    end

    assign ONES = ones_q;
    assign TENS = tens_q;

endmodule

// File: tb/tb_mp_counter.sv
// Directed self-checking bench for mp_counter with TICK_DIV=1, SCAN_DIV=1:
// every enabled edge counts and the display digit alternates every edge.
module tb_mp_counter;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic       STYLE;
    logic [6:0] DISP;
    logic [3:0] AN;
    logic [3:0] ONES;
    logic [3:0] TENS;

    int   checks = 0;
    int   errors = 0;
    logic expIdx = 1'b0;

    mp_counter #(.TICK_DIV(1), .SCAN_DIV(1)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .EN    (EN),
        .STYLE (STYLE),
        .DISP  (DISP),
        .AN    (AN),
        .ONES  (ONES),
        .TENS  (TENS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [6:0] segRef(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Drive inputs away from the rising edge, run n edges, then settle on the
    // falling edge so outputs are sampled mid-cycle.
    task automatic applyStimulus(input logic rst, input logic en,
                                 input logic style, input int n);
        RST   = rst;
        EN    = en;
        STYLE = style;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            expIdx = rst ? ~expIdx : 1'b0;
        end
        @(negedge CLK);
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expTens,
                               input logic [3:0] expOnes);
        logic [3:0] expAn;
        logic [6:0] expDisp;
        expAn   = expIdx ? 4'b1101 : 4'b1110;
        expDisp = expIdx ? segRef(expTens) : segRef(expOnes);
        checks++;
        assert (ONES === expOnes) else begin
            errors++;
            $error("[TB] FAIL %s ONES observed=%0d expected=%0d", tag, ONES, expOnes);
        end
        checks++;
        assert (TENS === expTens) else begin
            errors++;
            $error("[TB] FAIL %s TENS observed=%0d expected=%0d", tag, TENS, expTens);
        end
        checks++;
        assert (AN === expAn) else begin
            errors++;
            $error("[TB] FAIL %s AN observed=%b expected=%b", tag, AN, expAn);
        end
        checks++;
        assert (DISP === expDisp) else begin
            errors++;
            $error("[TB] FAIL %s DISP observed=%b expected=%b", tag, DISP, expDisp);
        end
    endtask

    initial begin
        RST   = 1'b0;
        EN    = 1'b0;
        STYLE = 1'b1;

        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput("reset", 4'd0, 4'd0);
        checks++;
        assert (AN === 4'b1110 && DISP === 7'b1000000) else begin
            errors++;
            $error("[TB] FAIL reset_display AN=%b DISP=%b expected AN=1110 DISP=1000000", AN, DISP);
        end

        applyStimulus(1'b1, 1'b1, 1'b1, 9);
        checkOutput("up_09", 4'd0, 4'd9);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        checkOutput("up_carry_10", 4'd1, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 5);
        checkOutput("up_15", 4'd1, 4'd5);

        applyStimulus(1'b1, 1'b1, 1'b1, 83);
        checkOutput("up_98", 4'd9, 4'd8);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        checkOutput("up_99", 4'd9, 4'd9);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        checkOutput("up_wrap_00", 4'd0, 4'd0);

        applyStimulus(1'b1, 1'b1, 1'b1, 3);
        checkOutput("up_03", 4'd0, 4'd3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput("reverse_02", 4'd0, 4'd2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        checkOutput("reverse_03", 4'd0, 4'd3);

        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        checkOutput("reset_pulse", 4'd0, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput("down_wrap_99", 4'd9, 4'd9);
        applyStimulus(1'b1, 1'b1, 1'b0, 9);
        checkOutput("down_90", 4'd9, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput("down_borrow_89", 4'd8, 4'd9);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1);
            checkOutput($sformatf("freeze_%0d", i), 4'd8, 4'd9);
        end

        applyStimulus(1'b1, 1'b1, 1'b0, 42);
        checkOutput("down_47", 4'd4, 4'd7);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("hold_47_other_digit", 4'd4, 4'd7);

        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        checkOutput("reset_midcount", 4'd0, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        checkOutput("resume_01", 4'd0, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
